tristate_bus_reader: RTL and testbench

Sequential read master for the shared tri-state data bus formed by the design's chip-selected registers. Each register drives the bus when its `cs` input is 0 and floats when it is 1. The block scans a contiguous, wrapping range of slave indices. For each slave it drives exactly one `cs` line low, waits a settle interval, captures the bus, and releases it. Each captured word goes out with its index and a one-cycle valid strobe. It sits between the feature-map register bank and the downstream accumulator/classifier logic.

---
 rtl/tristate_bus_reader.sv | 170 +++++++++++++++++
 tb/tb_tristate_bus_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_reader.sv
// rtl/tristate_bus_reader.sv - sequential chip-select read master for a shared tri-state bus
//
// Scans a contiguous, wrapping range of slave indices [first..last]. For each
// slave one cs line is driven low, the bus is given SettleCycles ticks to settle,
// then it is captured and emitted with its index and a one-cycle valid strobe.
//
// Optional feature macro: TRISTATE_BUS_TURNAROUND_EN
//   defined   : one all-deselected tick (TURN) between consecutive slaves
//   undefined : selections hand over back-to-back on a single edge
//
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   asynchronous, active-high reset
//   Tick   in   advance enable for FSM, settle counter and capture
//   start  in   scan request, sampled in IDLE on ticking edges
//   first  in   first slave index, latched at start
//   last   in   last slave index, latched at start
//   bus    in   shared tri-state data bus
//   cs     out  per-slave select, 0 = drive, at most one bit low
//   data   out  last captured word
//   idx    out  slave index of data
//   valid  out  one-Clock pulse, new data/idx
//   done   out  one-Clock pulse with the final valid of a scan
//   err    out  one-Clock pulse, start rejected (index out of range)
//   busy   out  high while a scan is in progress

module tristate_bus_reader #(
    parameter int NrOfBits     = 8,
    parameter int NrOfSlaves   = 4,
    parameter int IdxBits      = 2,
    parameter int SettleCycles = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Tick,
    input  logic                  start,
    input  logic [IdxBits-1:0]    first,
    input  logic [IdxBits-1:0]    last,
    input  logic [NrOfBits-1:0]   bus,
    output logic [NrOfSlaves-1:0] cs,
    output logic [NrOfBits-1:0]   data,
    output logic [IdxBits-1:0]    idx,
    output logic                  valid,
    output logic                  done,
    output logic                  err,
    output logic                  busy
);

    localparam int                 MaxIdxInt = NrOfSlaves - 1;
    localparam logic [IdxBits-1:0] MAX_IDX   = MaxIdxInt[IdxBits-1:0];
    localparam logic [IdxBits:0]   NSLV      = NrOfSlaves[IdxBits:0];
    localparam logic [3:0]         SETTLE    = SettleCycles[3:0];

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef TRISTATE_BUS_TURNAROUND_EN
        S_TURN,
`endif
        S_SEL
    } state_t;

    state_t                  state_q;
    logic [IdxBits-1:0]      cur_q;
    logic [IdxBits-1:0]      end_q;
    logic [3:0]              cnt_q;
    logic [NrOfSlaves-1:0]   cs_q;
    logic [NrOfBits-1:0]     data_q;
    logic [IdxBits-1:0]      idx_q;
    logic                    valid_q;
    logic                    done_q;
    logic                    err_q;
    logic                    busy_q;

    logic [IdxBits-1:0]      cur_d;
    logic [3:0]              cnt_d;
    logic                    range_ok;

    // Active-low one-hot select for a single slave.
    function automatic logic [NrOfSlaves-1:0] sel_mask(input logic [IdxBits-1:0] i);
        return ~({{(NrOfSlaves-1){1'b0}}, 1'b1} << i);
    endfunction

    assign cur_d    = (cur_q == MAX_IDX) ? '0 : cur_q + 1'b1;
    assign cnt_d    = cnt_q + 4'd1;
    assign range_ok = ({1'b0, first} < NSLV) && ({1'b0, last} < NSLV);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            cs_q    <= '1;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // Strobes are one Clock wide regardless of Tick.
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (Tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (range_ok) begin
                                cur_q   <= first;
                                end_q   <= last;
                                cnt_q   <= '0;
                                cs_q    <= sel_mask(first);
                                busy_q  <= 1'b1;
                                state_q <= S_SEL;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_SEL: begin
                        cnt_q <= cnt_d;
                        if (cnt_d == SETTLE) begin
                            // Capture and release happen on the same edge.
                            data_q  <= bus;
                            idx_q   <= cur_q;
                            valid_q <= 1'b1;
                            if (cur_q == end_q) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                cs_q    <= '1;
                                state_q <= S_IDLE;
                            end else begin
                                cur_q <= cur_d;
                                cnt_q <= '0;
`ifdef TRISTATE_BUS_TURNAROUND_EN
                                cs_q    <= '1;
                                state_q <= S_TURN;
`else
                                // Direct handover: old bit rises, new bit falls on one edge.
                                cs_q <= sel_mask(cur_d);
`endif
                            end
                        end
                    end
`ifdef TRISTATE_BUS_TURNAROUND_EN
                    S_TURN: begin
                        cs_q    <= sel_mask(cur_q);
                        state_q <= S_SEL;
                    end
`endif
                    default: begin
                        cs_q    <= '1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cs    = cs_q;
    assign data  = data_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_tristate_bus_reader.sv
// tb/tb_tristate_bus_reader.sv - self-checking bench for tristate_bus_reader

module tb_tristate_bus_reader;

    localparam int NS = 4;
`ifdef TRISTATE_BUS_TURNAROUND_EN
    localparam int TURN = 1;
`else
    localparam int TURN = 0;
`endif

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Tick;
    logic       start;
    logic [2:0] first;
    logic [2:0] last;

    logic [7:0] bus_a  [2];
    logic [3:0] cs_a   [2];
    logic [7:0] data_a [2];
    logic [2:0] idx_a  [2];
    logic [1:0] valid_a;
    logic [1:0] done_a;
    logic [1:0] err_a;
    logic [1:0] busy_a;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    function automatic logic [7:0] sval(input int i);
        case (i)
            0:       return 8'h5C;
            1:       return 8'hA1;
            2:       return 8'hB2;
            default: return 8'h3D;
        endcase
    endfunction

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Bus: the selected slave drives its word, otherwise a pull-up value.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            bus_a[k] = 8'hFF;
            for (int i = 0; i < NS; i++)
                if (!cs_a[k][i]) bus_a[k] = sval(i);
        end
    end

    tristate_bus_reader #(.NrOfBits(8), .NrOfSlaves(NS), .IdxBits(3), .SettleCycles(1)) u_s1 (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .start(start),
        .first(first), .last(last), .bus(bus_a[0]), .cs(cs_a[0]),
        .data(data_a[0]), .idx(idx_a[0]), .valid(valid_a[0]), .done(done_a[0]),
        .err(err_a[0]), .busy(busy_a[0])
    );

    tristate_bus_reader #(.NrOfBits(8), .NrOfSlaves(NS), .IdxBits(3), .SettleCycles(3)) u_s3 (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .start(start),
        .first(first), .last(last), .bus(bus_a[1]), .cs(cs_a[1]),
        .data(data_a[1]), .idx(idx_a[1]), .valid(valid_a[1]), .done(done_a[1]),
        .err(err_a[1]), .busy(busy_a[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a scan is "current slave + number of slaves still to read".
    bit         m_busy  [2] = '{0, 0};
    bit         m_gap   [2] = '{0, 0};
    int         m_cur   [2] = '{0, 0};
    int         m_left  [2] = '{0, 0};
    int         m_ph    [2] = '{0, 0};
    logic [7:0] m_data  [2] = '{8'h00, 8'h00};
    int         m_idx   [2] = '{0, 0};
    bit         m_valid [2] = '{0, 0};
    bit         m_done  [2] = '{0, 0};
    bit         m_err   [2] = '{0, 0};

    always @(posedge Clock or posedge Reset) begin
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            m_done[k]  = 0;
            m_err[k]   = 0;
            if (Reset) begin
                m_busy[k] = 0;
                m_gap[k]  = 0;
                m_data[k] = 8'h00;
                m_idx[k]  = 0;
            end else if (Tick) begin
                if (!m_busy[k]) begin
                    if (start) begin
                        if (int'(first) >= NS || int'(last) >= NS) begin
                            m_err[k] = 1;
                        end else begin
                            m_busy[k] = 1;
                            m_cur[k]  = int'(first);
                            m_left[k] = (int'(last) - int'(first) + NS) % NS + 1;
                            m_ph[k]   = 0;
                            m_gap[k]  = 0;
                        end
                    end
                end else if (m_gap[k]) begin
                    m_gap[k] = 0;
                end else begin
                    m_ph[k]++;
                    if (m_ph[k] == settle_of(k)) begin
                        m_valid[k] = 1;
                        m_data[k]  = sval(m_cur[k]);
                        m_idx[k]   = m_cur[k];
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            m_done[k] = 1;
                            m_busy[k] = 0;
                        end else begin
                            m_cur[k] = (m_cur[k] + 1) % NS;
                            m_ph[k]  = 0;
                            m_gap[k] = (TURN == 1);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [3:0] exp_cs(input int k);
        logic [3:0] m;
        m = 4'hF;
        if (m_busy[k] && !m_gap[k]) m[m_cur[k]] = 1'b0;
        return m;
    endfunction

    always @(negedge Clock) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cs%0d", k),    32'(cs_a[k]),   32'(exp_cs(k)));
            chk($sformatf("data%0d", k),  32'(data_a[k]), 32'(m_data[k]));
            chk($sformatf("idx%0d", k),   32'(idx_a[k]),  32'(m_idx[k]));
            chk($sformatf("valid%0d", k), 32'(valid_a[k]), 32'(m_valid[k]));
            chk($sformatf("done%0d", k),  32'(done_a[k]), 32'(m_done[k]));
            chk($sformatf("err%0d", k),   32'(err_a[k]),  32'(m_err[k]));
            chk($sformatf("busy%0d", k),  32'(busy_a[k]), 32'(m_busy[k]));
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy_a != 2'b00 && n < maxc) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy_a), 32'd0);
        step();
    endtask

    int         nv;
    int         low;
    logic [2:0] seen [4];

    initial begin
        Reset = 1'b1; Tick = 1'b1; start = 1'b0; first = 3'd0; last = 3'd0;
        step(); step();
        Reset = 1'b0;
        chk("rst_cs",   32'(cs_a[0]),   32'hF);
        chk("rst_data", 32'(data_a[0]), 32'h0);
        chk("rst_busy", 32'(busy_a),    32'h0);

        // Basic two-slave scan.
        first = 3'd1; last = 3'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_cs_a", 32'(cs_a[0]), 32'b1101);
        step();
        chk("t1_v1",  32'(valid_a[0]), 32'd1);
        chk("t1_d1",  32'(data_a[0]),  32'hA1);
        chk("t1_i1",  32'(idx_a[0]),   32'd1);
`ifdef TRISTATE_BUS_TURNAROUND_EN
        chk("t1_cs_gap", 32'(cs_a[0]), 32'b1111);
        step();
        chk("t1_cs_b", 32'(cs_a[0]), 32'b1011);
        step();
`else
        chk("t1_cs_b", 32'(cs_a[0]), 32'b1011);
        step();
`endif
        chk("t1_v2",   32'(valid_a[0]), 32'd1);
        chk("t1_d2",   32'(data_a[0]),  32'hB2);
        chk("t1_i2",   32'(idx_a[0]),   32'd2);
        chk("t1_done", 32'(done_a[0]),  32'd1);
        chk("t1_busy", 32'(busy_a[0]),  32'd0);
        chk("t1_cs_e", 32'(cs_a[0]),    32'b1111);
        wait_idle(40);

        // Wrap-around 3 -> 0.
        first = 3'd3; last = 3'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_cs", 32'(cs_a[0]), 32'b0111);
        nv = 0;
        for (int c = 0; c < 20 && busy_a[0]; c++) begin
            step();
            if (valid_a[0] && nv < 4) begin
                seen[nv] = idx_a[0];
                nv++;
            end
        end
        chk("t2_nvalid", 32'(nv), 32'd2);
        chk("t2_idx0",   32'(seen[0]), 32'd3);
        chk("t2_idx1",   32'(seen[1]), 32'd0);
        wait_idle(40);

        // Single slave, SettleCycles=3 instance.
        first = 3'd2; last = 3'd2; start = 1'b1;
        step();
        start = 1'b0;
        low = 0;
        for (int c = 0; c < 3; c++) begin
            if (!cs_a[1][2]) low++;
            step();
        end
        chk("t3_low",  32'(low),         32'd3);
        chk("t3_done", 32'(done_a[1]),   32'd1);
        chk("t3_val",  32'(valid_a[1]),  32'd1);
        chk("t3_data", 32'(data_a[1]),   32'hB2);
        chk("t3_cs",   32'(cs_a[1]),     32'b1111);
        wait_idle(40);

        // Out-of-range start.
        first = 3'd5; last = 3'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_err",  32'(err_a),   32'b11);
        chk("t4_busy", 32'(busy_a),  32'b00);
        chk("t4_cs",   32'(cs_a[0]), 32'hF);
        step();
        chk("t4_err_clr", 32'(err_a), 32'b00);

        // Tick toggling, start pulsed mid-scan.
        first = 3'd0; last = 3'd1; start = 1'b1;
        step();
        start = 1'b0;
        nv = 0;
        for (int c = 0; c < 60 && busy_a != 2'b00; c++) begin
            Tick  = c[0];
            start = (c == 3);
            if (c == 3) begin
                first = 3'd3; last = 3'd3;
            end
            step();
            if (valid_a[0]) nv++;
        end
        Tick = 1'b1; start = 1'b0;
        chk("t5_nvalid", 32'(nv), 32'd2);
        step(); step();
        chk("t5_nostart", 32'(busy_a), 32'd0);

        // Asynchronous reset mid-scan.
        first = 3'd1; last = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_cs_sel", 32'(cs_a[0]), 32'b1101);
        #2 Reset = 1'b1;
        #1;
        chk("t6_cs_rst",   32'(cs_a[0]), 32'hF);
        chk("t6_cs3_rst",  32'(cs_a[1]), 32'hF);
        chk("t6_busy_rst", 32'(busy_a),  32'd0);
        step();
        Reset = 1'b0;
        step(); step();
        chk("t6_quiet", 32'({valid_a, done_a, busy_a}), 32'd0);
        first = 3'd2; last = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_restart", 32'(cs_a[0]), 32'b1011);
        wait_idle(40);

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
